// File: rtl/c64_bus_pkg.sv
// rtl/c64_bus_pkg.sv - shared encodings for the C64 RAM bus arbiter
package c64_bus_pkg;

  // Arbitration state: CPU running, BA grace period, video owns phase 1
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STEAL = 2'd1,
    DMA   = 2'd2
  } arb_state_t;

  // Slot phase within one CPU bus cycle
  localparam logic PH_VID = 1'b0;
  localparam logic PH_CPU = 1'b1;

  // Full bus cycles between BA falling and AEC falling
  localparam int BA_DELAY_DEF = 3;

endpackage

// File: rtl/c64_ba_timer.sv
// rtl/c64_ba_timer.sv - BA/AEC handshake timer and phase-1 grant decision
module c64_ba_timer
  import c64_bus_pkg::*;
#(
  parameter int BA_DELAY = BA_DELAY_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic step,     // high in the phase-0 slot: next edge enters phase 1
  input  logic dma_req,
  input  logic cpu_we,
  output logic cpu_go,   // CPU owns the coming phase-1 slot and advances
  output logic vid_go,   // video DMA owns the coming phase-1 slot
  output logic ba,
  output logic aec
);

  localparam int CW = (BA_DELAY > 1) ? $clog2(BA_DELAY) : 1;

  arb_state_t    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          ba_d, aec_d;

  // State, grace counter and handshake lines advance once per bus cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
      ba    <= 1'b1;
      aec   <= 1'b1;
    end else if (step) begin
      state <= state_d;
      cnt   <= cnt_d;
      ba    <= ba_d;
      aec   <= aec_d;
    end
  end

  // Next state and grant for the upcoming phase-1 slot; writes may finish during the grace period
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ba_d    = ba;
    aec_d   = aec;
    cpu_go  = 1'b0;
    vid_go  = 1'b0;
    case (state)
      RUN: begin
        cpu_go = 1'b1;
        if (dma_req) begin
          state_d = STEAL;
          ba_d    = 1'b0;
          cnt_d   = CW'(BA_DELAY - 1);
        end
      end
      STEAL: begin
        if (!dma_req) begin
          state_d = RUN;
          ba_d    = 1'b1;
          cpu_go  = 1'b1;
        end else if (cnt == '0) begin
          state_d = DMA;
          aec_d   = 1'b0;
          vid_go  = 1'b1;
        end else begin
          cnt_d  = cnt - 1'b1;
          cpu_go = cpu_we;
        end
      end
      DMA: begin
        if (!dma_req) begin
          state_d = RUN;
          ba_d    = 1'b1;
          aec_d   = 1'b1;
          cpu_go  = 1'b1;
        end else begin
          vid_go = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        ba_d    = 1'b1;
        aec_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/c64_bus_arbiter.sv
// rtl/c64_bus_arbiter.sv - two-slot RAM multiplexer between 6502 core and video fetch
module c64_bus_arbiter
  import c64_bus_pkg::*;
#(
  parameter int BA_DELAY = BA_DELAY_DEF,
  parameter int AW       = 16,
  parameter int DW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_ab,
  input  logic [DW-1:0] cpu_do,
  input  logic          cpu_we,
  output logic [DW-1:0] cpu_di,
  output logic          cpu_ce,
  input  logic [AW-1:0] vid_ab,
  input  logic          vid_dma_req,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  output logic          vid_dma,
  output logic          ba,
  output logic          aec,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  logic phase;
  logic cpu_go, vid_go;
  logic slot_cpu_go;   // current/last phase-1 slot let the CPU advance
  logic slot_dma;      // current/last phase-1 slot was a video DMA fetch

  // The core reads straight off the RAM during its cpu_ce slot
  assign cpu_di = mem_rdata;

  c64_ba_timer #(
    .BA_DELAY(BA_DELAY)
  ) u_ba_timer (
    .clk    (clk),
    .reset  (reset),
    .step   (phase == PH_VID),
    .dma_req(vid_dma_req),
    .cpu_we (cpu_we),
    .cpu_go (cpu_go),
    .vid_go (vid_go),
    .ba     (ba),
    .aec    (aec)
  );

  // Slot sequencing: load the RAM port for the next slot and capture the previous slot's data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase       <= PH_VID;
      slot_cpu_go <= 1'b0;
      slot_dma    <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      cpu_ce      <= 1'b0;
      vid_data    <= '0;
      vid_valid   <= 1'b0;
      vid_dma     <= 1'b0;
    end else begin
      phase <= (phase == PH_VID) ? PH_CPU : PH_VID;
      if (phase == PH_VID) begin
        slot_cpu_go <= cpu_go;
        slot_dma    <= vid_go;
        cpu_ce      <= 1'b0;
        if (vid_go) begin
          mem_addr <= vid_ab;
          mem_we   <= 1'b0;
        end else begin
          // A stalled slot still presents cpu_ab but never writes
          mem_addr <= cpu_ab;
          mem_we   <= cpu_go & cpu_we;
          if (cpu_go) mem_wdata <= cpu_do;
        end
        vid_valid <= slot_dma;
        vid_dma   <= slot_dma;
        if (slot_dma) vid_data <= mem_rdata;
      end else begin
        mem_addr  <= vid_ab;
        mem_we    <= 1'b0;
        cpu_ce    <= slot_cpu_go;
        vid_data  <= mem_rdata;
        vid_valid <= 1'b1;
        vid_dma   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// tb/tb_c64_bus_arbiter.sv - directed vector bench for c64_bus_arbiter
module tb_c64_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_do;
  logic        cpu_we;
  logic [7:0]  cpu_di;
  logic        cpu_ce;
  logic [15:0] vid_ab;
  logic        vid_dma_req;
  logic [7:0]  vid_data;
  logic        vid_valid;
  logic        vid_dma;
  logic        ba;
  logic        aec;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  logic        ram_init;
  logic [7:0]  ram [0:65535];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] ab;
    logic [7:0]  dout;
    logic        we;
    logic [15:0] vab;
    logic        req;
    logic [15:0] e_addr;
    logic        e_we;
    logic [7:0]  e_wd;
    logic        e_ce;
    logic [7:0]  e_di;
    logic        e_vv;
    logic        e_vd;
    logic [7:0]  e_vdat;
    logic        e_ba;
    logic        e_aec;
  } vec_t;

  vec_t vq[$];

  c64_bus_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_ab     (cpu_ab),
    .cpu_do     (cpu_do),
    .cpu_we     (cpu_we),
    .cpu_di     (cpu_di),
    .cpu_ce     (cpu_ce),
    .vid_ab     (vid_ab),
    .vid_dma_req(vid_dma_req),
    .vid_data   (vid_data),
    .vid_valid  (vid_valid),
    .vid_dma    (vid_dma),
    .ba         (ba),
    .aec        (aec),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [15:0] a);
    case (a)
      16'h1000: return 8'hA9;
      16'h1001: return 8'hEA;
      16'h0800: return 8'h20;
      16'h0C00: return 8'hC0;
      16'h0C01: return 8'hC1;
      16'h0C02: return 8'hC2;
      default:  return 8'h00;
    endcase
  endfunction

  // Synchronous RAM model: one-clk read latency, read-before-write
  always @(posedge clk) begin
    if (ram_init) begin
      for (int a = 0; a < 65536; a++) ram[a] <= init_byte(16'(a));
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic [15:0] ab, input logic [7:0] dout, input logic we,
                     input logic [15:0] vab, input logic req,
                     input logic [15:0] e_addr, input logic e_we, input logic [7:0] e_wd,
                     input logic e_ce, input logic [7:0] e_di, input logic e_vv,
                     input logic e_vd, input logic [7:0] e_vdat, input logic e_ba,
                     input logic e_aec);
    vec_t v;
    v = '{ab, dout, we, vab, req, e_addr, e_we, e_wd, e_ce, e_di, e_vv, e_vd, e_vdat, e_ba, e_aec};
    vq.push_back(v);
  endtask

  initial begin
    // reads, write, read-back, DMA steal with reads, DMA exit, steal with writes, exit, read-back
    add(16'h1000, 8'h00, 0, 16'h0800, 0, 16'h1000, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 1);
    add(16'h1000, 8'h00, 0, 16'h0800, 0, 16'h0800, 0, 8'h00, 1, 8'hA9, 1, 0, 8'h00, 1, 1);
    add(16'h1001, 8'h00, 0, 16'h0800, 0, 16'h1001, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 1);
    add(16'h1001, 8'h00, 0, 16'h0800, 1, 16'h0800, 0, 8'h00, 1, 8'hEA, 1, 0, 8'h20, 1, 1);
    add(16'h0400, 8'h55, 1, 16'h0800, 0, 16'h0400, 1, 8'h55, 0, 8'h00, 0, 0, 8'h00, 1, 1);
    add(16'h0400, 8'h55, 1, 16'h0800, 0, 16'h0800, 0, 8'h00, 1, 8'h00, 1, 0, 8'h20, 1, 1);
    add(16'h0400, 8'h00, 0, 16'h0800, 0, 16'h0400, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 1);
    add(16'h0400, 8'h00, 0, 16'h0800, 0, 16'h0800, 0, 8'h00, 1, 8'h55, 1, 0, 8'h20, 1, 1);
    add(16'h1000, 8'h00, 0, 16'h0800, 1, 16'h1000, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    add(16'h1000, 8'h00, 0, 16'h0800, 1, 16'h0800, 0, 8'h00, 1, 8'hA9, 1, 0, 8'h20, 0, 1);
    add(16'h1000, 8'h00, 0, 16'h0800, 1, 16'h1000, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    add(16'h1000, 8'h00, 0, 16'h0800, 1, 16'h0800, 0, 8'h00, 0, 8'h00, 1, 0, 8'h20, 0, 1);
    add(16'h1000, 8'h00, 0, 16'h0800, 1, 16'h1000, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    add(16'h1000, 8'h00, 0, 16'h0800, 1, 16'h0800, 0, 8'h00, 0, 8'h00, 1, 0, 8'h20, 0, 1);
    add(16'h1000, 8'h00, 0, 16'h0C00, 1, 16'h0C00, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    add(16'h1000, 8'h00, 0, 16'h0800, 1, 16'h0800, 0, 8'h00, 0, 8'h00, 1, 0, 8'h20, 0, 0);
    add(16'h1000, 8'h00, 0, 16'h0C01, 1, 16'h0C01, 0, 8'h00, 0, 8'h00, 1, 1, 8'hC0, 0, 0);
    add(16'h1000, 8'h00, 0, 16'h0800, 1, 16'h0800, 0, 8'h00, 0, 8'h00, 1, 0, 8'h20, 0, 0);
    add(16'h1000, 8'h00, 0, 16'h0800, 0, 16'h1000, 0, 8'h00, 0, 8'h00, 1, 1, 8'hC1, 1, 1);
    add(16'h1000, 8'h00, 0, 16'h0800, 1, 16'h0800, 0, 8'h00, 1, 8'hA9, 1, 0, 8'h20, 1, 1);
    add(16'h0401, 8'h11, 1, 16'h0800, 1, 16'h0401, 1, 8'h11, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    add(16'h0401, 8'h11, 1, 16'h0800, 1, 16'h0800, 0, 8'h00, 1, 8'h00, 1, 0, 8'h20, 0, 1);
    add(16'h0402, 8'h22, 1, 16'h0800, 1, 16'h0402, 1, 8'h22, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    add(16'h0402, 8'h22, 1, 16'h0800, 1, 16'h0800, 0, 8'h00, 1, 8'h00, 1, 0, 8'h20, 0, 1);
    add(16'h0403, 8'h33, 1, 16'h0800, 1, 16'h0403, 1, 8'h33, 0, 8'h00, 0, 0, 8'h00, 0, 1);
    add(16'h0403, 8'h33, 1, 16'h0800, 1, 16'h0800, 0, 8'h00, 1, 8'h00, 1, 0, 8'h20, 0, 1);
    add(16'h0404, 8'h44, 1, 16'h0C02, 1, 16'h0C02, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    add(16'h0404, 8'h44, 1, 16'h0800, 0, 16'h0800, 0, 8'h00, 0, 8'h00, 1, 0, 8'h20, 0, 0);
    add(16'h0401, 8'h00, 0, 16'h0800, 0, 16'h0401, 0, 8'h00, 0, 8'h00, 1, 1, 8'hC2, 1, 1);
    add(16'h0401, 8'h00, 0, 16'h0800, 0, 16'h0800, 0, 8'h00, 1, 8'h11, 1, 0, 8'h20, 1, 1);
    add(16'h0403, 8'h00, 0, 16'h0800, 0, 16'h0403, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 1, 1);
    add(16'h0403, 8'h00, 0, 16'h0800, 0, 16'h0800, 0, 8'h00, 1, 8'h33, 1, 0, 8'h20, 1, 1);

    reset       = 1'b1;
    ram_init    = 1'b1;
    cpu_ab      = 16'h1000;
    cpu_do      = 8'h00;
    cpu_we      = 1'b0;
    vid_ab      = 16'h0800;
    vid_dma_req = 1'b0;
    @(negedge clk);
    ram_init = 1'b0;
    cyc();
    cyc();

    chk("rst_ba",        0, 32'(ba),        32'd1);
    chk("rst_aec",       0, 32'(aec),       32'd1);
    chk("rst_cpu_ce",    0, 32'(cpu_ce),    32'd0);
    chk("rst_mem_we",    0, 32'(mem_we),    32'd0);
    chk("rst_mem_addr",  0, 32'(mem_addr),  32'd0);
    chk("rst_mem_wdata", 0, 32'(mem_wdata), 32'd0);
    chk("rst_vid_data",  0, 32'(vid_data),  32'd0);
    chk("rst_vid_valid", 0, 32'(vid_valid), 32'd0);
    chk("rst_vid_dma",   0, 32'(vid_dma),   32'd0);

    reset = 1'b0;
    for (int i = 0; i < vq.size(); i++) begin
      cpu_ab      = vq[i].ab;
      cpu_do      = vq[i].dout;
      cpu_we      = vq[i].we;
      vid_ab      = vq[i].vab;
      vid_dma_req = vq[i].req;
      cyc();
      chk("mem_addr",  i, 32'(mem_addr),  32'(vq[i].e_addr));
      chk("mem_we",    i, 32'(mem_we),    32'(vq[i].e_we));
      chk("cpu_ce",    i, 32'(cpu_ce),    32'(vq[i].e_ce));
      chk("vid_valid", i, 32'(vid_valid), 32'(vq[i].e_vv));
      chk("vid_dma",   i, 32'(vid_dma),   32'(vq[i].e_vd));
      chk("ba",        i, 32'(ba),        32'(vq[i].e_ba));
      chk("aec",       i, 32'(aec),       32'(vq[i].e_aec));
      if (vq[i].e_we) chk("mem_wdata", i, 32'(mem_wdata), 32'(vq[i].e_wd));
      if (vq[i].e_ce) chk("cpu_di",    i, 32'(cpu_di),    32'(vq[i].e_di));
      if (vq[i].e_vv) chk("vid_data",  i, 32'(vid_data),  32'(vq[i].e_vdat));
    end

    // Enter DMA with CPU reads, then reset asynchronously mid-cycle
    cpu_ab      = 16'h1000;
    cpu_we      = 1'b0;
    vid_ab      = 16'h0C00;
    vid_dma_req = 1'b1;
    for (int k = 0; k < 8; k++) cyc();
    chk("dma_pre_ba",  100, 32'(ba),  32'd0);
    chk("dma_pre_aec", 100, 32'(aec), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("arst_ba",        101, 32'(ba),        32'd1);
    chk("arst_aec",       101, 32'(aec),       32'd1);
    chk("arst_cpu_ce",    101, 32'(cpu_ce),    32'd0);
    chk("arst_mem_we",    101, 32'(mem_we),    32'd0);
    chk("arst_mem_addr",  101, 32'(mem_addr),  32'd0);
    chk("arst_mem_wdata", 101, 32'(mem_wdata), 32'd0);
    chk("arst_vid_data",  101, 32'(vid_data),  32'd0);
    chk("arst_vid_valid", 101, 32'(vid_valid), 32'd0);
    chk("arst_vid_dma",   101, 32'(vid_dma),   32'd0);
    @(negedge clk);
    @(negedge clk);
    reset       = 1'b0;
    vid_dma_req = 1'b0;
    vid_ab      = 16'h0800;
    cyc();
    chk("post_mem_addr", 102, 32'(mem_addr), 32'h1000);
    chk("post_cpu_ce",   102, 32'(cpu_ce),   32'd0);
    chk("post_ba",       102, 32'(ba),       32'd1);
    chk("post_aec",      102, 32'(aec),      32'd1);
    cyc();
    chk("post_cpu_ce2",  103, 32'(cpu_ce),   32'd1);
    chk("post_cpu_di",   103, 32'(cpu_di),   32'hA9);
    chk("post_mem_addr2",103, 32'(mem_addr), 32'h0800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
